// File: rtl/sc_fifo.sv
// Single-clock FIFO with a power-of-two depth, an unreset storage array and a registered read port.
// Optional occupancy count and sticky overflow/underflow flags are enabled by defining FIFO_SC_STATUS_EN.
module sc_fifo #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  empty,
  output logic                  full
`ifdef FIFO_SC_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovfl,
  output logic                  udfl
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  we;
  logic                  re;

  // Pointers carry an extra wrap bit: equal addresses mean empty when the
  // wrap bits match and full when they differ.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign we = write && !full;
  assign re = read && !empty;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + PTR_ONE;
      if (re) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Handshake: valid is high for exactly one cycle per popped word, in the
  // cycle after the pop; data_out holds its last word while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= re;
      if (re) data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

`ifdef FIFO_SC_STATUS_EN
  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovfl <= 1'b0;
      udfl <= 1'b0;
    end else begin
      if (write && full) ovfl <= 1'b1;
      if (read && empty) udfl <= 1'b1;
    end
  end
`else
  // Status outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_sc_fifo.sv
// Self-checking bench for sc_fifo: directed test-plan steps followed by random traffic,
// all compared against a queue-based reference model. Status checks follow FIFO_SC_STATUS_EN.
module tb_sc_fifo;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [DW-1:0] data_in;
  logic          read;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          empty;
  logic          full;
`ifdef FIFO_SC_STATUS_EN
  logic [AW:0]   count;
  logic          ovfl;
  logic          udfl;
`endif

  sc_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .data_in  (data_in),
    .read     (read),
    .data_out (data_out),
    .valid    (valid),
    .empty    (empty),
    .full     (full)
`ifdef FIFO_SC_STATUS_EN
    ,
    .count    (count),
    .ovfl     (ovfl),
    .udfl     (udfl)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovfl;
  logic          m_udfl;

  int total = 0;
  int bad   = 0;
  int eof_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
    bit pre_full;
    bit pre_empty;
    write   = w;
    read    = r;
    data_in = d;
    rst     = rs;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovfl  = 1'b0;
      m_udfl  = 1'b0;
    end else begin
      pre_full  = (exp_q.size() == DEPTH);
      pre_empty = (exp_q.size() == 0);
      m_valid   = r && !pre_empty;
      if (m_valid) m_data = exp_q.pop_front();
      if (w && !pre_full) exp_q.push_back(d);
      if (w && pre_full) m_ovfl = 1'b1;
      if (r && pre_empty) m_udfl = 1'b1;
    end
    #1;
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("valid", 32'(valid), 32'(m_valid));
    check("data_out", 32'(data_out), 32'(m_data));
`ifdef FIFO_SC_STATUS_EN
    check("count", 32'(count), 32'(exp_q.size()));
    check("ovfl", 32'(ovfl), 32'(m_ovfl));
    check("udfl", 32'(udfl), 32'(m_udfl));
`endif
    if (valid && empty) eof_cnt++;
    write = 1'b0;
    read  = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    write   = 1'b0;
    read    = 1'b0;
    data_in = '0;
    rst     = 1'b1;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovfl  = 1'b0;
    m_udfl  = 1'b0;

    // Reset state
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Three writes then three reads; end-of-frame seen exactly once
    eof_cnt = 0;
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    check("last_word", 32'(data_out), 32'h33);
    step(0, 0, 8'h00, 0);
    check("eof_once", 32'(eof_cnt), 32'd1);

    // Read while empty after reset
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    check("udfl_data_zero", 32'(data_out), 32'h0);

    // Fill to full, dropped 17th write, drain
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i), 0);
    check("full_after_16", 32'(full), 32'd1);
    step(1, 0, 8'hAA, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 8'h00, 0);
      check("drain_order", 32'(data_out), 32'(i));
    end
    step(0, 1, 8'h00, 0);

    // Full: simultaneous write/read returns the oldest word
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'h40 + i), 0);
    step(1, 1, 8'hC3, 0);
    check("full_wr_rd_oldest", 32'(data_out), 32'h40);

    // Steady one-word occupancy with simultaneous write/read
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    for (int i = 1; i <= 100; i++) begin
      step(1, 1, DW'(i), 0);
      check("stream_seq", 32'(data_out), 32'(DW'(i - 1)));
    end

    // Simultaneous write/read on an empty FIFO: no bypass
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h5A, 0);
    check("nobypass_valid", 32'(valid), 32'd0);
    check("nobypass_empty", 32'(empty), 32'd0);
    step(0, 1, 8'h00, 0);
    check("nobypass_word", 32'(data_out), 32'h5A);

    // Reset with contents and read high
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1, 0, DW'(8'hE0 + i), 0);
    step(0, 1, 8'h00, 0);
    write = 1'b0;
    step(1, 1, 8'h77, 1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_data", 32'(data_out), 32'd0);

    // Random traffic
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           DW'($urandom_range(0, 255)), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
